// File: rtl/adc8_eoc_emulator_pkg.sv
// adc8_eoc_emulator_pkg: FSM state encodings and default timing shared by the ADC emulators.
package adc8_eoc_emulator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        SETUP  = 2'd2,
        EOC_LO = 2'd3
    } state_t;

    localparam int DEF_N_BIT  = 8;
    localparam int DEF_T_CONV = 200;
    localparam int DEF_T_EOC  = 50;
    localparam int DEF_CNT_W  = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-FF synchronizer followed by a registered rising-edge pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic meta, s1, s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            s1   <= 1'b0;
            s2   <= 1'b0;
            rise <= 1'b0;
        end else begin
            meta <= async_in;
            s1   <= meta;
            s2   <= s1;
            rise <= s1 & ~s2;
        end
    end

endmodule

// File: rtl/adc8_eoc_emulator.sv
// adc8_eoc_emulator: CONVST-triggered 8-bit ADC responder driving DATA and an active-low EOC pulse.
module adc8_eoc_emulator
    import adc8_eoc_emulator_pkg::*;
#(
    parameter int N_BIT  = DEF_N_BIT,
    parameter int T_CONV = DEF_T_CONV,
    parameter int T_EOC  = DEF_T_EOC,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_CONVST,
    input  logic [N_BIT-1:0] i_sample,
    output logic [N_BIT-1:0] o_DATA,
    output logic             o_EOC,
    output logic             o_busy,
    output logic             o_overrun,
    output logic [CNT_W-1:0] o_conv_cnt
);

    localparam int TW = $clog2(max_int(T_CONV, T_EOC) + 1);

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic [N_BIT-1:0] smp, smp_n, data_n;
    logic [CNT_W-1:0] cnt_n;
    logic             eoc_n, busy_n, ovr_n, rise;

    sync_edge_detect u_sync (
        .clk      (i_CLK),
        .rst_n    (i_RST),
        .async_in (i_CONVST),
        .rise     (rise)
    );

    always_comb begin
        state_n = state;
        timer_n = timer;
        smp_n   = smp;
        data_n  = o_DATA;
        eoc_n   = o_EOC;
        busy_n  = o_busy;
        cnt_n   = o_conv_cnt;
        // Any edge outside IDLE, including the EOC_LO exit cycle, is dropped and flagged.
        ovr_n   = o_overrun | (rise && state != IDLE);
        case (state)
            IDLE: if (rise) begin
                state_n = CONV;
                smp_n   = i_sample;
                timer_n = TW'(T_CONV - 1);
                busy_n  = 1'b1;
            end
            CONV: if (timer == '0) begin
                state_n = SETUP;
                data_n  = smp;
            end else begin
                timer_n = timer - TW'(1);
            end
            SETUP: begin
                state_n = EOC_LO;
                eoc_n   = 1'b0;
                timer_n = TW'(T_EOC - 1);
            end
            EOC_LO: if (timer == '0) begin
                state_n = IDLE;
                eoc_n   = 1'b1;
                busy_n  = 1'b0;
                cnt_n   = o_conv_cnt + CNT_W'(1);
            end else begin
                timer_n = timer - TW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state      <= IDLE;
            timer      <= '0;
            smp        <= '0;
            o_DATA     <= '0;
            o_EOC      <= 1'b1;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
            o_conv_cnt <= '0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            smp        <= smp_n;
            o_DATA     <= data_n;
            o_EOC      <= eoc_n;
            o_busy     <= busy_n;
            o_overrun  <= ovr_n;
            o_conv_cnt <= cnt_n;
        end
    end

endmodule
